lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Multi-cycle load/store unit sitting directly downstream of the control decoder.
- Consumes the decoder's store one-hot, load-select code and memory-write enable, plus the ALU address and the rs2 store data.
- Drives a request/acknowledge data-memory port with byte-lane masks. Returns sign- or zero-extended load data for writeback.
- Stalls the core while a memory access is outstanding.

Parameters:
- MEM_AW, 12, word-address width of the data memory; o_mem_addr = i_addr[MEM_AW+1:2].
- TIMEOUT, 16, maximum cycles in REQ without i_mem_ack before the access is aborted (≥2).

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous active-low reset
- i_lsu_req  in  1  current instruction is a load or store (decoder mem_wren | data_sel)
- i_mem_wren  in  1  1 = store, 0 = load
- i_st  in  3  store one-hot {sw,sh,sb}
- i_sl_sel  in  3  load code: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
- i_addr  in  32  effective byte address from ALU
- i_st_data  in  32  rs2 store data
- o_stall  out  1  hold PC/pipeline this cycle
- o_done  out  1  one-cycle pulse: access finished, o_ld_data valid
- o_ld_data  out  32  extended load result (registered)
- o_misaligned  out  1  with o_done: access rejected for alignment
- o_err  out  1  with o_done: timeout or illegal type
- o_mem_req  out  1  memory request valid
- o_mem_we  out  1  write strobe
- o_mem_addr  out  MEM_AW  word address
- o_mem_wdata  out  32  lane-replicated store data
- o_mem_bmask  out  4  byte-enable mask
- i_mem_ack  in  1  memory accepted (write) / rdata valid (read)
- i_mem_rdata  in  32  read word

Behaviour:
- Reset (i_reset=0, async): state IDLE. Counter 0. All outputs 0, including o_ld_data. Latched address, data and type cleared.
- FSM states: IDLE, REQ, DONE.
- IDLE, i_lsu_req=0:
  - o_stall=0; no memory activity.
- IDLE, i_lsu_req=1:
  - o_stall=1 combinationally.
  - Latch addr, data, type, we.
  - If misaligned: next state DONE with misaligned flag. Misaligned means halfword (lh/lhu/sh) with addr[0]=1, or word (lw/sw) with addr[1:0]≠0.
  - Else if illegal: next state DONE with err flag. Illegal means store with i_st not one-hot, or load with i_sl_sel ≥101.
  - Else: next state REQ, counter cleared.
- REQ:
  - o_stall=1, o_mem_req=1.
  - Memory outputs driven from latched values and held stable until ack.
  - On i_mem_ack: load writes the extracted value into o_ld_data; store leaves o_ld_data=0. Next state DONE.
  - No ack: counter increments. If counter = TIMEOUT-1 with no ack, drop o_mem_req and go DONE with err flag.
- DONE:
  - o_stall=0, o_done=1 for exactly one cycle.
  - o_misaligned/o_err reflect the latched flags; flags clear on exit.
  - Always returns to IDLE; i_lsu_req is ignored in DONE (no re-issue of the same instruction).
- Load latency: ≥3 cycles (IDLE→REQ→DONE) with zero-wait memory. Each wait cycle adds one.
- On error/misaligned, o_ld_data=0 and no memory request is ever asserted.
- Store lanes (o_mem_we=1 in REQ only):
  - sb: bmask = 0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - sh: bmask = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - sw: bmask = 1111, wdata = data.
- Loads: o_mem_we=0, bmask=1111.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8]; halfword = rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- o_ld_data holds its value until the next completed load, error or reset.
- Reset mid-REQ: o_mem_req drops immediately and asynchronously; the access is abandoned.
- i_mem_ack outside REQ is ignored.

Test Plan:
- lb at addr 0x103, rdata 0x80FF_1234 → bmask 1111, o_mem_addr 0x040, o_ld_data 0xFFFF_FF80, o_done 1 cycle, o_stall high for exactly 2 cycles with zero-wait ack.
- lhu at 0x102, rdata 0x8001_0000 → o_ld_data 0x0000_8001; same request as lh → 0xFFFF_8001.
- sb at 0x201, data 0x1234_56AB, ack after 3 wait cycles → o_mem_we 1, bmask 0010, wdata 0xABAB_ABAB held stable for all 4 REQ cycles; o_done after ack.
- lw at 0x0000_0006 → o_mem_req never asserted, o_misaligned=1 and o_done=1 in the same cycle, o_ld_data 0.
- lw with no ack, TIMEOUT=16 → o_mem_req high for 16 cycles, then o_err+o_done pulse, o_stall released.
- i_reset asserted low during the 2nd REQ cycle of sw → o_mem_req, o_stall, o_ld_data go 0 immediately; after release the FSM is in IDLE, and a new lw at 0x0 completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: decodes access type, drives a req/ack data-memory
// port with byte lanes, and returns sign/zero-extended load data for writeback.
module lsu_ctrl #(
    parameter int MEM_AW  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_lsu_req,
    input  logic              i_mem_wren,
    input  logic [2:0]        i_st,
    input  logic [2:0]        i_sl_sel,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_st_data,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_ld_data,
    output logic              o_misaligned,
    output logic              o_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [MEM_AW+1:0]   r_addr;
    logic [31:0]         r_data;
    logic [31:0]         r_ld_data;
    logic                r_we;
    logic [2:0]          r_st;
    logic [2:0]          r_sl;
    logic                r_mis;
    logic                r_err;

    logic                w_in_half;
    logic                w_in_word;
    logic                w_in_mis;
    logic                w_in_ill;
    logic                w_timeout;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ld_ext;
    logic [3:0]          w_st_mask;
    logic [31:0]         w_st_wdata;
    logic                w_unused;

    // Upper address bits lie outside the data memory and are never used.
    assign w_unused = ^i_addr[31:MEM_AW+2];

    // Classification of the incoming instruction, evaluated only in IDLE.
    assign w_in_half = i_mem_wren ? (i_st == 3'b010)
                                  : ((i_sl_sel == 3'b001) || (i_sl_sel == 3'b100));
    assign w_in_word = i_mem_wren ? (i_st == 3'b100) : (i_sl_sel == 3'b010);
    assign w_in_mis  = (w_in_half & i_addr[0]) | (w_in_word & (|i_addr[1:0]));
    assign w_in_ill  = i_mem_wren ? !((i_st == 3'b001) || (i_st == 3'b010) || (i_st == 3'b100))
                                  : (i_sl_sel > 3'b100);
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    assign w_byte = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = i_mem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_ext = i_mem_rdata;
        case (r_sl)
            3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
            3'b011:  w_ld_ext = {24'd0, w_byte};
            3'b100:  w_ld_ext = {16'd0, w_half};
            default: w_ld_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        w_st_mask  = 4'b1111;
        w_st_wdata = r_data;
        case (r_st)
            3'b001: begin
                w_st_mask  = 4'b0001 << r_addr[1:0];
                w_st_wdata = {4{r_data[7:0]}};
            end
            3'b010: begin
                w_st_mask  = r_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{r_data[15:0]}};
            end
            default: begin
                w_st_mask  = 4'b1111;
                w_st_wdata = r_data;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_lsu_req) w_next = (w_in_mis || w_in_ill) ? S_DONE : S_REQ;
            S_REQ:  if (i_mem_ack || w_timeout) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_stall      = 1'b0;
        o_done       = 1'b0;
        o_misaligned = 1'b0;
        o_err        = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_bmask  = '0;
        case (r_state)
            S_IDLE: o_stall = i_lsu_req;
            S_REQ: begin
                o_stall     = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = r_addr[MEM_AW+1:2];
                o_mem_wdata = r_we ? w_st_wdata : 32'd0;
                o_mem_bmask = r_we ? w_st_mask : 4'b1111;
            end
            S_DONE: begin
                o_done       = 1'b1;
                o_misaligned = r_mis;
                o_err        = r_err;
            end
            default: o_stall = 1'b0;
        endcase
    end

    assign o_ld_data = r_ld_data;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_ld_data <= '0;
            r_we      <= 1'b0;
            r_st      <= '0;
            r_sl      <= '0;
            r_mis     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_lsu_req) begin
                        r_addr <= i_addr[MEM_AW+1:0];
                        r_data <= i_st_data;
                        r_we   <= i_mem_wren;
                        r_st   <= i_st;
                        r_sl   <= i_sl_sel;
                        r_mis  <= w_in_mis;
                        r_err  <= !w_in_mis && w_in_ill;
                        r_cnt  <= '0;
                        if (w_in_mis || w_in_ill) r_ld_data <= '0;
                    end
                end
                S_REQ: begin
                    if (i_mem_ack) begin
                        r_ld_data <= r_we ? 32'd0 : w_ld_ext;
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_ld_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_mis <= 1'b0;
                    r_err <= 1'b0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// checked against an arithmetic reference model of the load/store rules.
module tb_lsu_ctrl;
    localparam int AW = 12;
    localparam int TO = 16;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_lsu_req = 1'b0;
    logic          i_mem_wren = 1'b0;
    logic [2:0]    i_st = '0;
    logic [2:0]    i_sl_sel = '0;
    logic [31:0]   i_addr = '0;
    logic [31:0]   i_st_data = '0;
    logic          o_stall, o_done, o_misaligned, o_err;
    logic [31:0]   o_ld_data;
    logic          o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [3:0]    o_mem_bmask;
    logic          i_mem_ack = 1'b0;
    logic [31:0]   i_mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Observations collected by the access driver.
    int            obs_req_cyc, obs_stall_cyc;
    logic          obs_stable, obs_we, obs_done, obs_mis, obs_errf, obs_stall_done, obs_req_done, obs_done_next;
    logic [3:0]    obs_bmask;
    logic [31:0]   obs_wdata, obs_ld, obs_ld_next;
    logic [AW-1:0] obs_addr;

    lsu_ctrl #(.MEM_AW(AW), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_lsu_req(i_lsu_req), .i_mem_wren(i_mem_wren),
        .i_st(i_st), .i_sl_sel(i_sl_sel), .i_addr(i_addr), .i_st_data(i_st_data),
        .o_stall(o_stall), .o_done(o_done), .o_ld_data(o_ld_data), .o_misaligned(o_misaligned),
        .o_err(o_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: expected load result from the extraction rules.
    function automatic logic [31:0] ref_load(input logic [2:0] sl, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> ((addr % 4) * 8)) & 32'hFF;
        h = (rdata >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
        case (sl)
            3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd3: return b;
            3'd4: return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic ref_mis(input logic we, input logic [2:0] st, input logic [2:0] sl, input logic [31:0] addr);
        logic half, word;
        half = we ? (st == 3'd2) : (sl == 3'd1 || sl == 3'd4);
        word = we ? (st == 3'd4) : (sl == 3'd2);
        return (half && (addr % 2) != 0) || (word && (addr % 4) != 0);
    endfunction

    function automatic logic ref_ill(input logic we, input logic [2:0] st, input logic [2:0] sl);
        return we ? !(st == 3'd1 || st == 3'd2 || st == 3'd4) : (sl > 3'd4);
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] st, input logic [31:0] addr);
        if (st == 3'd1) return 4'(1 << (addr % 4));
        if (st == 3'd2) return ((addr / 2) % 2 != 0) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] st, input logic [31:0] d);
        if (st == 3'd1) return (d & 32'hFF) * 32'h0101_0101;
        if (st == 3'd2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Issues one access from IDLE, services memory, records what the DUT did.
    task automatic do_access(input logic we, input logic [2:0] st, input logic [2:0] sl,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int wait_cyc, input logic [31:0] rdata, input logic noack);
        int guard;
        i_lsu_req = 1'b1; i_mem_wren = we; i_st = st; i_sl_sel = sl; i_addr = addr; i_st_data = data;
        #1;
        obs_stall_cyc = o_stall ? 1 : 0;
        obs_req_cyc = 0; obs_stable = 1'b1;
        obs_we = 1'b0; obs_bmask = '0; obs_wdata = '0; obs_addr = '0;
        @(posedge i_clk); #1;
        i_lsu_req = 1'b0;
        guard = 0;
        while (o_mem_req === 1'b1 && guard < 64) begin
            if (obs_req_cyc == 0) begin
                obs_we = o_mem_we; obs_bmask = o_mem_bmask; obs_wdata = o_mem_wdata; obs_addr = o_mem_addr;
            end else if (o_mem_we !== obs_we || o_mem_bmask !== obs_bmask ||
                         o_mem_wdata !== obs_wdata || o_mem_addr !== obs_addr) begin
                obs_stable = 1'b0;
            end
            if (o_stall === 1'b1) obs_stall_cyc++;
            if (!noack && obs_req_cyc == wait_cyc) begin
                i_mem_ack = 1'b1; i_mem_rdata = rdata;
            end
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0; i_mem_rdata = $urandom;
            obs_req_cyc++; guard++;
        end
        obs_done = o_done; obs_mis = o_misaligned; obs_errf = o_err; obs_ld = o_ld_data;
        obs_stall_done = o_stall; obs_req_done = o_mem_req;
        @(posedge i_clk); #1;
        obs_done_next = o_done; obs_ld_next = o_ld_data;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_cmp++; if ({o_stall, o_done, o_misaligned, o_err, o_mem_req, o_mem_we} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got %b want 000000", {o_stall, o_done, o_misaligned, o_err, o_mem_req, o_mem_we}); end
        n_cmp++; if (o_ld_data !== 32'd0) begin n_err++; $display("FAIL reset_ld: got %h want 0", o_ld_data); end
        n_cmp++; if ({o_mem_addr, o_mem_wdata, o_mem_bmask} !== '0) begin n_err++; $display("FAIL reset_mem: got %h/%h/%b want 0", o_mem_addr, o_mem_wdata, o_mem_bmask); end
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        n_cmp++; if ({o_stall, o_done, o_mem_req} !== 3'b0) begin n_err++; $display("FAIL idle_after_reset: got %b want 000", {o_stall, o_done, o_mem_req}); end
    endtask

    task automatic test_lb();
        do_access(1'b0, 3'd0, 3'd0, 32'h103, 32'd0, 0, 32'h80FF_1234, 1'b0);
        n_cmp++; if (obs_bmask !== 4'b1111 || obs_we !== 1'b0) begin n_err++; $display("FAIL lb_lanes: got we=%b mask=%b want 0/1111", obs_we, obs_bmask); end
        n_cmp++; if (obs_addr !== 12'h040) begin n_err++; $display("FAIL lb_addr: got %h want 040", obs_addr); end
        n_cmp++; if (obs_ld !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", obs_ld); end
        n_cmp++; if (obs_stall_cyc !== 2 || obs_req_cyc !== 1) begin n_err++; $display("FAIL lb_stall: got stall=%0d req=%0d want 2/1", obs_stall_cyc, obs_req_cyc); end
        n_cmp++; if (obs_done !== 1'b1 || obs_done_next !== 1'b0 || obs_stall_done !== 1'b0) begin n_err++; $display("FAIL lb_done_pulse: got %b%b stall=%b want 10 stall=0", obs_done, obs_done_next, obs_stall_done); end
        n_cmp++; if (obs_ld_next !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_hold: got %h want ffffff80", obs_ld_next); end
    endtask

    task automatic test_lh();
        do_access(1'b0, 3'd0, 3'd4, 32'h102, 32'd0, 0, 32'h8001_0000, 1'b0);
        n_cmp++; if (obs_ld !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_data: got %h want 00008001", obs_ld); end
        do_access(1'b0, 3'd0, 3'd1, 32'h102, 32'd0, 0, 32'h8001_0000, 1'b0);
        n_cmp++; if (obs_ld !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_data: got %h want ffff8001", obs_ld); end
    endtask

    task automatic test_ack_idle();
        for (int i = 0; i < 3; i++) begin
            i_mem_ack = 1'b1; i_mem_rdata = $urandom;
            @(posedge i_clk); #1;
            n_cmp++; if (o_done !== 1'b0 || o_mem_req !== 1'b0 || o_ld_data !== 32'hFFFF_8001) begin n_err++; $display("FAIL ack_in_idle: got done=%b req=%b ld=%h want 0/0/ffff8001", o_done, o_mem_req, o_ld_data); end
        end
        i_mem_ack = 1'b0;
    endtask

    task automatic test_sb_wait();
        do_access(1'b1, 3'd1, 3'd0, 32'h201, 32'h1234_56AB, 3, 32'd0, 1'b0);
        n_cmp++; if (obs_we !== 1'b1 || obs_bmask !== 4'b0010) begin n_err++; $display("FAIL sb_lanes: got we=%b mask=%b want 1/0010", obs_we, obs_bmask); end
        n_cmp++; if (obs_wdata !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb_wdata: got %h want abababab", obs_wdata); end
        n_cmp++; if (obs_req_cyc !== 4 || obs_stable !== 1'b1) begin n_err++; $display("FAIL sb_hold: got req=%0d stable=%b want 4/1", obs_req_cyc, obs_stable); end
        n_cmp++; if (obs_done !== 1'b1 || obs_errf !== 1'b0 || obs_mis !== 1'b0) begin n_err++; $display("FAIL sb_done: got %b%b%b want 100", obs_done, obs_errf, obs_mis); end
    endtask

    task automatic test_misaligned();
        do_access(1'b0, 3'd0, 3'd1, 32'h0, 32'd0, 0, 32'h5555_AAAA, 1'b0);
        do_access(1'b0, 3'd0, 3'd2, 32'h6, 32'd0, 0, 32'h1234_5678, 1'b0);
        n_cmp++; if (obs_req_cyc !== 0 || obs_req_done !== 1'b0) begin n_err++; $display("FAIL mis_no_req: got req cycles=%0d want 0", obs_req_cyc); end
        n_cmp++; if (obs_done !== 1'b1 || obs_mis !== 1'b1 || obs_errf !== 1'b0) begin n_err++; $display("FAIL mis_flags: got done=%b mis=%b err=%b want 1/1/0", obs_done, obs_mis, obs_errf); end
        n_cmp++; if (obs_ld !== 32'd0) begin n_err++; $display("FAIL mis_ld: got %h want 0", obs_ld); end
        n_cmp++; if (obs_stall_cyc !== 1) begin n_err++; $display("FAIL mis_stall: got %0d want 1", obs_stall_cyc); end
    endtask

    task automatic test_illegal();
        do_access(1'b1, 3'd3, 3'd0, 32'h40, 32'hFFFF_FFFF, 0, 32'd0, 1'b0);
        n_cmp++; if (obs_req_cyc !== 0 || obs_errf !== 1'b1 || obs_mis !== 1'b0 || obs_done !== 1'b1) begin n_err++; $display("FAIL ill_store: got req=%0d err=%b mis=%b done=%b want 0/1/0/1", obs_req_cyc, obs_errf, obs_mis, obs_done); end
        do_access(1'b0, 3'd0, 3'd6, 32'h40, 32'd0, 0, 32'd0, 1'b0);
        n_cmp++; if (obs_req_cyc !== 0 || obs_errf !== 1'b1 || obs_ld !== 32'd0) begin n_err++; $display("FAIL ill_load: got req=%0d err=%b ld=%h want 0/1/0", obs_req_cyc, obs_errf, obs_ld); end
        n_cmp++; if (obs_done_next !== 1'b0) begin n_err++; $display("FAIL ill_flags_clear: got done=%b want 0", obs_done_next); end
    endtask

    task automatic test_timeout();
        do_access(1'b0, 3'd0, 3'd2, 32'h80, 32'd0, 0, 32'd0, 1'b1);
        n_cmp++; if (obs_req_cyc !== TO) begin n_err++; $display("FAIL to_req_cycles: got %0d want %0d", obs_req_cyc, TO); end
        n_cmp++; if (obs_done !== 1'b1 || obs_errf !== 1'b1 || obs_mis !== 1'b0) begin n_err++; $display("FAIL to_flags: got done=%b err=%b mis=%b want 1/1/0", obs_done, obs_errf, obs_mis); end
        n_cmp++; if (obs_stall_done !== 1'b0 || obs_stall_cyc !== TO + 1 || obs_ld !== 32'd0) begin n_err++; $display("FAIL to_release: got stall=%b cyc=%0d ld=%h want 0/%0d/0", obs_stall_done, obs_stall_cyc, obs_ld, TO + 1); end
    endtask

    task automatic test_random();
        logic we; logic [2:0] st, sl; logic [31:0] addr, data, rdata; int w; int pick;
        logic mis, ill;
        for (int it = 0; it < 60; it++) begin
            we = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 3);
            st = (pick == 0) ? 3'd1 : (pick == 1) ? 3'd2 : (pick == 2) ? 3'd4 : 3'($urandom_range(0, 7));
            sl = 3'($urandom_range(0, 7));
            addr = $urandom; data = $urandom; rdata = $urandom;
            w = $urandom_range(0, 3);
            mis = ref_mis(we, st, sl, addr);
            ill = !mis && ref_ill(we, st, sl);
            do_access(we, st, sl, addr, data, w, rdata, 1'b0);
            n_cmp++; if (obs_done !== 1'b1 || obs_mis !== mis || obs_errf !== ill || obs_done_next !== 1'b0) begin n_err++; $display("FAIL rnd_flags[%0d]: got done=%b mis=%b err=%b want 1/%b/%b", it, obs_done, obs_mis, obs_errf, mis, ill); end
            if (mis || ill) begin
                n_cmp++; if (obs_req_cyc !== 0 || obs_ld !== 32'd0) begin n_err++; $display("FAIL rnd_reject[%0d]: got req=%0d ld=%h want 0/0", it, obs_req_cyc, obs_ld); end
            end else begin
                n_cmp++; if (obs_req_cyc !== w + 1 || obs_stable !== 1'b1 || obs_addr !== addr[AW+1:2]) begin n_err++; $display("FAIL rnd_req[%0d]: got cyc=%0d stable=%b addr=%h want %0d/1/%h", it, obs_req_cyc, obs_stable, obs_addr, w + 1, addr[AW+1:2]); end
                if (we) begin
                    n_cmp++; if (obs_we !== 1'b1 || obs_bmask !== ref_mask(st, addr) || obs_wdata !== ref_wdata(st, data)) begin n_err++; $display("FAIL rnd_store[%0d]: got we=%b mask=%b wd=%h want 1/%b/%h", it, obs_we, obs_bmask, obs_wdata, ref_mask(st, addr), ref_wdata(st, data)); end
                end else begin
                    n_cmp++; if (obs_we !== 1'b0 || obs_bmask !== 4'b1111 || obs_ld !== ref_load(sl, addr, rdata) || obs_ld_next !== ref_load(sl, addr, rdata)) begin n_err++; $display("FAIL rnd_load[%0d]: got mask=%b ld=%h want 1111/%h", it, obs_bmask, obs_ld, ref_load(sl, addr, rdata)); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] rd;
        do_access(1'b0, 3'd0, 3'd2, 32'h10, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
        n_cmp++; if (obs_ld !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pre_reset_lw: got %h want deadbeef", obs_ld); end
        i_lsu_req = 1'b1; i_mem_wren = 1'b1; i_st = 3'd4; i_addr = 32'h300; i_st_data = $urandom;
        @(posedge i_clk); #1;
        i_lsu_req = 1'b0;
        @(posedge i_clk); #1;
        n_cmp++; if (o_mem_req !== 1'b1 || o_stall !== 1'b1) begin n_err++; $display("FAIL sw_in_req: got req=%b stall=%b want 1/1", o_mem_req, o_stall); end
        i_reset = 1'b0;
        #1;
        n_cmp++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_ld_data !== 32'd0 || o_mem_we !== 1'b0) begin n_err++; $display("FAIL async_reset: got req=%b stall=%b ld=%h we=%b want 0/0/0/0", o_mem_req, o_stall, o_ld_data, o_mem_we); end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        n_cmp++; if (o_mem_req !== 1'b0 || o_done !== 1'b0 || o_stall !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got req=%b done=%b stall=%b want 0/0/0", o_mem_req, o_done, o_stall); end
        rd = $urandom;
        do_access(1'b0, 3'd0, 3'd2, 32'h0, 32'd0, 1, rd, 1'b0);
        n_cmp++; if (obs_ld !== rd || obs_req_cyc !== 2 || obs_addr !== 12'h000 || obs_done !== 1'b1 || obs_errf !== 1'b0) begin n_err++; $display("FAIL post_reset_lw: got ld=%h cyc=%0d done=%b want %h/2/1", obs_ld, obs_req_cyc, obs_done, rd); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lh();
        test_ack_idle();
        test_sb_wait();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_random();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
